// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ALU decode/issue register (one-entry ID/EX stage)
//
// Purpose: decodes an RV32I instruction into an ALU operation and its two
//   operands, then holds the result in a single valid/ready register toward EX.
//   Supports flush and counts every entry consumed by EX.
// Optional feature macro: ALU_ISSUE_ILLEGAL_EN
//   defined     - unknown opcodes are issued with `illegal`=1, aluop=0, a=b=0, rd_wen=0
//   not defined - unknown opcodes are accepted and silently dropped (no `illegal` port)
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   flush                       kill held entry and the instruction offered this cycle
//   in_valid / in_ready         decode-side handshake for inst, pc, rs1_data, rs2_data
//   out_valid / out_ready       EX-side handshake for the held entry
//   aluop, opr_a, opr_b         ALU operation and operands
//   st_data                     rs2 value carried for stores
//   rd_addr, rd_wen             destination register and write enable
//   illegal                     entry holds an illegal instruction (macro builds only)
//   issue_cnt                   entries consumed by EX, wraps to 0
module alu_issue_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       aluop,
  output logic [XLEN-1:0]  opr_a,
  output logic [XLEN-1:0]  opr_b,
  output logic [XLEN-1:0]  st_data,
  output logic [4:0]       rd_addr,
  output logic             rd_wen,
`ifdef ALU_ISSUE_ILLEGAL_EN
  output logic             illegal,
`endif
  output logic [CNT_W-1:0] issue_cnt
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic            f7b;
  logic [XLEN-1:0] imm_i, imm_s, imm_u, shamt;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7b    = inst[30];
  assign imm_i  = XLEN'($signed(inst[31:20]));
  assign imm_s  = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign imm_u  = XLEN'($signed({inst[31:12], 12'b0}));
  assign shamt  = XLEN'(inst[24:20]);

  logic            dec_legal;
  logic [3:0]      dec_aluop;
  logic [XLEN-1:0] dec_a, dec_b;
  logic            dec_wen;

  always_comb begin
    dec_legal = 1'b1;
    dec_aluop = 4'b0000;
    dec_a     = rs1_data;
    dec_b     = imm_i;
    dec_wen   = 1'b1;
    case (opcode)
      OPC_OP: begin
        dec_aluop = {f7b, f3};
        dec_b     = rs2_data;
      end
      OPC_OPIMM: begin
        // Only srai uses inst[30] as an op bit; the other I-type ops treat it as immediate.
        dec_aluop = {(f3 == 3'b101) && f7b, f3};
        // Shift immediates carry only shamt so the funct7 bits never reach operand B.
        if (f3 == 3'b001 || f3 == 3'b101) begin
          dec_b = shamt;
        end
      end
      OPC_LUI: begin
        dec_aluop = 4'b1111;
        dec_a     = '0;
        dec_b     = imm_u;
      end
      OPC_AUIPC: begin
        dec_a = pc;
        dec_b = imm_u;
      end
      OPC_LOAD: begin
        dec_b = imm_i;
      end
      OPC_STORE: begin
        dec_b   = imm_s;
        dec_wen = 1'b0;
      end
      default: begin
        dec_legal = 1'b0;
        dec_a     = '0;
        dec_b     = '0;
        dec_wen   = 1'b0;
      end
    endcase
    if (inst[11:7] == 5'd0) begin
      dec_wen = 1'b0;
    end
  end

  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       aluop_q;
  logic [XLEN-1:0]  opr_a_q, opr_b_q, st_data_q;
  logic [4:0]       rd_addr_q;
  logic             rd_wen_q;
  logic             consume, accept, load;

  // Flush always frees the slot so the upstream handshake never blocks on a dying entry.
  assign in_ready = !valid_q || out_ready || flush;
  assign consume  = valid_q && out_ready;
  assign accept   = in_valid && in_ready && !flush;
`ifdef ALU_ISSUE_ILLEGAL_EN
  assign load     = accept;
`else
  // Illegal instructions complete the handshake but never occupy the register.
  assign load     = accept && dec_legal;
`endif

  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (consume) begin
      cnt_d   = cnt_q + CNT_W'(1);
      valid_d = 1'b0;
    end
    if (load) begin
      valid_d = 1'b1;
    end
    if (flush) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      cnt_q     <= '0;
      aluop_q   <= 4'b0000;
      opr_a_q   <= '0;
      opr_b_q   <= '0;
      st_data_q <= '0;
      rd_addr_q <= 5'd0;
      rd_wen_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      if (load) begin
        aluop_q   <= dec_aluop;
        opr_a_q   <= dec_a;
        opr_b_q   <= dec_b;
        st_data_q <= rs2_data;
        rd_addr_q <= inst[11:7];
        rd_wen_q  <= dec_wen;
      end
    end
  end

`ifdef ALU_ISSUE_ILLEGAL_EN
  logic illegal_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (load) begin
      illegal_q <= !dec_legal;
    end
  end

  assign illegal = illegal_q;
`endif

  assign out_valid = valid_q;
  assign aluop     = aluop_q;
  assign opr_a     = opr_a_q;
  assign opr_b     = opr_b_q;
  assign st_data   = st_data_q;
  assign rd_addr   = rd_addr_q;
  assign rd_wen    = rd_wen_q;
  assign issue_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - self-checking bench for alu_issue_stage
module tb_alu_issue_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
`ifdef ALU_ISSUE_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_SUB = 32'h402081B3;
  localparam logic [31:0] I_LUI = 32'h123452B7;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready, rd_wen;
  logic [31:0]      inst, pc, rs1_data, rs2_data, opr_a, opr_b, st_data;
  logic [3:0]       aluop;
  logic [4:0]       rd_addr;
  logic [CNT_W-1:0] issue_cnt;
`ifdef ALU_ISSUE_ILLEGAL_EN
  logic             illegal;
`endif

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .aluop(aluop), .opr_a(opr_a),
    .opr_b(opr_b), .st_data(st_data), .rd_addr(rd_addr), .rd_wen(rd_wen),
`ifdef ALU_ISSUE_ILLEGAL_EN
    .illegal(illegal),
`endif
    .issue_cnt(issue_cnt)
  );

  typedef struct {
    logic        iss;
    logic        ill;
    logic [3:0]  op;
    logic [31:0] a, b, st;
    logic [4:0]  rd;
    logic        wen;
  } ent_t;

  typedef struct {
    logic [31:0] inst, pc, rs1, rs2;
    logic        v;
    logic        ill;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic        wen;
  } vec_t;

  int   n_pass = 0;
  int   n_total = 0;
  ent_t m_ent;
  logic m_v = 1'b0;
  int   m_cnt = 0;
  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
  endtask

  function automatic logic [31:0] sext12(input logic [11:0] v);
    int x;
    x = int'(v);
    if (x >= 2048) x = x - 4096;
    return 32'(x);
  endfunction

  // Reference decode written straight from the instruction-format rules.
  function automatic ent_t ref_decode(input logic [31:0] in, input logic [31:0] p,
                                      input logic [31:0] r1, input logic [31:0] r2);
    ent_t e;
    logic [2:0] f3;
    f3    = in[14:12];
    e.iss = 1'b1;
    e.ill = 1'b0;
    e.op  = 4'h0;
    e.a   = r1;
    e.b   = 32'h0;
    e.st  = r2;
    e.rd  = in[11:7];
    e.wen = 1'b1;
    case (in[6:0])
      7'h33: begin e.op = {in[30], f3}; e.b = r2; end
      7'h13: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.b  = 32'(in[24:20]);
          e.op = {(f3 == 3'd5) && in[30], f3};
        end else begin
          e.b  = sext12(in[31:20]);
          e.op = {1'b0, f3};
        end
      end
      7'h37: begin e.op = 4'hF; e.a = 32'h0; e.b = {in[31:12], 12'h000}; end
      7'h17: begin e.a = p; e.b = {in[31:12], 12'h000}; end
      7'h03: e.b = sext12(in[31:20]);
      7'h23: begin e.b = sext12({in[31:25], in[11:7]}); e.wen = 1'b0; end
      default: begin e.iss = ILL_EN; e.ill = 1'b1; e.a = 32'h0; e.b = 32'h0; e.wen = 1'b0; end
    endcase
    if (e.rd == 5'd0) e.wen = 1'b0;
    return e;
  endfunction

  function automatic logic [31:0] rnd_inst();
    logic [31:0] r;
    logic [6:0]  opc;
    r = $urandom();
    case ($urandom_range(0, 7))
      0: opc = 7'h33;
      1: opc = 7'h13;
      2: opc = 7'h37;
      3: opc = 7'h17;
      4: opc = 7'h03;
      5: opc = 7'h23;
      6: opc = 7'h73;
      default: opc = 7'h0F;
    endcase
    return {r[31:7], opc};
  endfunction

  // One clock: drive, compare DUT to model, advance model. Enter/exit on negedge.
  task automatic cyc(input logic iv, input logic [31:0] in, input logic [31:0] p,
                     input logic [31:0] r1, input logic [31:0] r2,
                     input logic ordy, input logic fl);
    ent_t d;
    logic exp_rdy, cons;
    in_valid = iv; inst = in; pc = p; rs1_data = r1; rs2_data = r2;
    out_ready = ordy; flush = fl;
    #1;
    exp_rdy = !m_v || ordy || fl;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(m_v));
    chk("issue_cnt", 32'(issue_cnt), 32'(m_cnt));
    if (m_v) begin
      chk("aluop", 32'(aluop), 32'(m_ent.op));
      chk("opr_a", opr_a, m_ent.a);
      chk("opr_b", opr_b, m_ent.b);
      chk("st_data", st_data, m_ent.st);
      chk("rd_addr", 32'(rd_addr), 32'(m_ent.rd));
      chk("rd_wen", 32'(rd_wen), 32'(m_ent.wen));
`ifdef ALU_ISSUE_ILLEGAL_EN
      chk("illegal", 32'(illegal), 32'(m_ent.ill));
`endif
    end
    cons = m_v && ordy;
    d    = ref_decode(in, p, r1, r2);
    if (cons) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    if (fl) m_v = 1'b0;
    else if (iv && exp_rdy && d.iss) begin m_v = 1'b1; m_ent = d; end
    else if (cons) m_v = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    inst = 32'h0; pc = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_aluop", 32'(aluop), 32'h0);
    chk("rst_a", opr_a, 32'h0);
    chk("rst_b", opr_b, 32'h0);
    chk("rst_st", st_data, 32'h0);
    chk("rst_rd", 32'(rd_addr), 32'h0);
    chk("rst_wen", 32'(rd_wen), 32'h0);
    chk("rst_cnt", 32'(issue_cnt), 32'h0);
`ifdef ALU_ISSUE_ILLEGAL_EN
    chk("rst_illegal", 32'(illegal), 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0; m_v = 1'b0; m_cnt = 0;
  endtask

  initial begin
    logic [31:0] ii;
    //           inst          pc          rs1           rs2         v       ill   op    a             b             rd  wen
    tbl[0]  = '{I_ADD,        32'h100, 32'd5,        32'd7,   1'b1,   1'b0, 4'h0, 32'd5,        32'd7,        5'd3, 1'b1};
    tbl[1]  = '{I_SUB,        32'h100, 32'd5,        32'd7,   1'b1,   1'b0, 4'h8, 32'd5,        32'd7,        5'd3, 1'b1};
    tbl[2]  = '{32'h4030D213, 32'h100, 32'h80000000, 32'd7,   1'b1,   1'b0, 4'hD, 32'h80000000, 32'd3,        5'd4, 1'b1};
    tbl[3]  = '{32'h0030D213, 32'h100, 32'h80000000, 32'd7,   1'b1,   1'b0, 4'h5, 32'h80000000, 32'd3,        5'd4, 1'b1};
    tbl[4]  = '{I_LUI,        32'h100, 32'd5,        32'd7,   1'b1,   1'b0, 4'hF, 32'd0,        32'h12345000, 5'd5, 1'b1};
    tbl[5]  = '{32'h00001317, 32'h100, 32'd5,        32'd7,   1'b1,   1'b0, 4'h0, 32'h100,      32'h1000,     5'd6, 1'b1};
    tbl[6]  = '{32'hFFC0A383, 32'h100, 32'd5,        32'd7,   1'b1,   1'b0, 4'h0, 32'd5,        32'hFFFFFFFC, 5'd7, 1'b1};
    tbl[7]  = '{32'h0020A423, 32'h100, 32'd5,        32'd7,   1'b1,   1'b0, 4'h0, 32'd5,        32'd8,        5'd8, 1'b0};
    tbl[8]  = '{32'h00108013, 32'h100, 32'd5,        32'd7,   1'b1,   1'b0, 4'h0, 32'd5,        32'd1,        5'd0, 1'b0};
    tbl[9]  = '{32'hFFF0C493, 32'h100, 32'd5,        32'd7,   1'b1,   1'b0, 4'h4, 32'd5,        32'hFFFFFFFF, 5'd9, 1'b1};
    tbl[10] = '{32'h4020D1B3, 32'h100, 32'd5,        32'd7,   1'b1,   1'b0, 4'hD, 32'd5,        32'd7,        5'd3, 1'b1};
    tbl[11] = '{32'h000000F3, 32'h100, 32'd5,        32'd7,   ILL_EN, 1'b1, 4'h0, 32'd0,        32'd0,        5'd1, 1'b0};

    do_reset();

    foreach (tbl[i]) begin
      cyc(1'b1, tbl[i].inst, tbl[i].pc, tbl[i].rs1, tbl[i].rs2, 1'b1, 1'b0);
      #1;
      chk("tbl_valid", 32'(out_valid), 32'(tbl[i].v));
      if (tbl[i].v) begin
        chk("tbl_aluop", 32'(aluop), 32'(tbl[i].op));
        chk("tbl_a", opr_a, tbl[i].a);
        chk("tbl_b", opr_b, tbl[i].b);
        chk("tbl_st", st_data, tbl[i].rs2);
        chk("tbl_rd", 32'(rd_addr), 32'(tbl[i].rd));
        chk("tbl_wen", 32'(rd_wen), 32'(tbl[i].wen));
`ifdef ALU_ISSUE_ILLEGAL_EN
        chk("tbl_illegal", 32'(illegal), 32'(tbl[i].ill));
`endif
      end
    end
    cyc(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Stall: held add stays frozen for three cycles while a sub is offered.
    do_reset();
    cyc(1'b1, I_ADD, 32'h100, 32'd5, 32'd7, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, I_SUB, 32'h104, 32'd9, 32'd9, 1'b0, 1'b0);
      chk("stall_aluop", 32'(aluop), 32'h0);
      chk("stall_a", opr_a, 32'd5);
      chk("stall_b", opr_b, 32'd7);
      chk("stall_rdy", 32'(in_ready), 32'h0);
      chk("stall_cnt", 32'(issue_cnt), 32'h0);
    end
    cyc(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("stall_release_cnt", 32'(issue_cnt), 32'h1);

    // Back-to-back issue, then continue to 16 consumes to see the counter wrap.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      ii = 32'h00108013 | (32'(k + 1) << 7);
      cyc(1'b1, ii, 32'h0, 32'd1, 32'd2, 1'b1, 1'b0);
      chk("b2b_valid", 32'(out_valid), 32'h1);
    end
    cyc(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("b2b_cnt", 32'(issue_cnt), 32'd4);
    chk("b2b_drain", 32'(out_valid), 32'h0);
    for (int k = 0; k < 12; k++) begin
      cyc(1'b1, I_ADD, 32'h0, 32'(k), 32'h3, 1'b1, 1'b0);
    end
    cyc(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("wrap_cnt", 32'(issue_cnt), 32'h0);

    // Flush with entry held and an instruction offered; then flush during a consume.
    cyc(1'b1, I_ADD, 32'h0, 32'd5, 32'd7, 1'b0, 1'b0);
    cyc(1'b1, I_LUI, 32'h0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_cnt", 32'(issue_cnt), 32'h0);
    cyc(1'b1, I_ADD, 32'h0, 32'd5, 32'd7, 1'b0, 1'b0);
    cyc(1'b1, I_LUI, 32'h0, 32'd0, 32'd0, 1'b1, 1'b1);
    chk("flush_cons_valid", 32'(out_valid), 32'h0);
    chk("flush_cons_cnt", 32'(issue_cnt), 32'h1);

    // Reset mid-stall, asserted between clock edges.
    cyc(1'b1, I_ADD, 32'h0, 32'd5, 32'd7, 1'b0, 1'b0);
    cyc(1'b1, I_SUB, 32'h0, 32'd6, 32'd8, 1'b0, 1'b0);
    do_reset();

    // Randomized traffic against the reference model.
    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0, 3) != 0, rnd_inst(), $urandom(), $urandom(), $urandom(),
          $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
